// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encoding and sizing for the 2x2 matrix multiplier sequencer.
package matmul_pkg;
  typedef enum logic [2:0] {LOAD, ARM, WAIT, CAPTURE, UNLOAD} state_t;
  localparam int N_OPERANDS = 8;
  localparam int N_RESULTS = 4;
  localparam int DEF_DW = 8;
  localparam int DEF_RW = 16;
  localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/matmul_out_mux.sv
// matmul_out_mux: selects one captured result word for the output stream.
module matmul_out_mux #(
  parameter int RW = 16
) (
  input  logic [3:0][RW-1:0] words,
  input  logic [1:0]         sel,
  output logic [RW-1:0]      word
);
  assign word = words[sel];
endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: loads 8 operand bytes, re-arms the multiplier, waits for done,
// captures the four results and streams them out word by word.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int RW = DEF_RW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] mul_a1,
  output logic [DW-1:0] mul_a2,
  output logic [DW-1:0] mul_a3,
  output logic [DW-1:0] mul_a4,
  output logic [DW-1:0] mul_b1,
  output logic [DW-1:0] mul_b2,
  output logic [DW-1:0] mul_b3,
  output logic [DW-1:0] mul_b4,
  output logic          mul_rst,
  input  logic [RW-1:0] mul_r1,
  input  logic [RW-1:0] mul_r2,
  input  logic [RW-1:0] mul_r3,
  input  logic [RW-1:0] mul_r4,
  input  logic          mul_done,
  output logic [RW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t                            state;
  logic [2:0]                        idx;
  logic [1:0]                        widx;
  logic [TW-1:0]                     timer;
  logic [N_OPERANDS-1:0][DW-1:0]     ops;
  logic [N_RESULTS-1:0][RW-1:0]      res;
  assign {mul_b4, mul_b3, mul_b2, mul_b1, mul_a4, mul_a3, mul_a2, mul_a1} = ops;
  matmul_out_mux #(.RW(RW)) u_mux (.words(res), .sel(widx), .word(out_data));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      idx         <= '0;
      widx        <= '0;
      timer       <= '0;
      ops         <= '0;
      res         <= '0;
      mul_rst     <= 1'b1;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          ops[idx] <= in_data;
          busy     <= 1'b1;
          idx      <= idx + 3'd1;
          if (idx == 3'd7) begin
            state    <= ARM;
            in_ready <= 1'b0;
          end
        end
        ARM: begin
          state   <= WAIT;
          mul_rst <= 1'b0;
          timer   <= '0;
        end
        WAIT: if (mul_done) state <= CAPTURE;
        else if (timer == TW'(TIMEOUT - 1)) begin
          // multiplier never answered: drop the job and return to loading
          err_timeout <= 1'b1;
          state       <= LOAD;
          mul_rst     <= 1'b1;
          in_ready    <= 1'b1;
          busy        <= 1'b0;
        end else timer <= timer + 1'b1;
        CAPTURE: begin
          res       <= {mul_r4, mul_r3, mul_r2, mul_r1};
          state     <= UNLOAD;
          out_valid <= 1'b1;
        end
        UNLOAD: if (out_ready) begin
          widx <= widx + 2'd1;
          if (widx == 2'd3) begin
            state     <= LOAD;
            out_valid <= 1'b0;
            mul_rst   <= 1'b1;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: random jobs through the sequencer and a stub multiplier,
// results compared against a matrix-product reference.
module tb_matmul_seq_ctrl;
  logic        clk = 0, rst_n = 0;
  logic [7:0]  in_data = 0;
  logic        in_valid = 0, in_ready;
  logic [7:0]  mul_a1, mul_a2, mul_a3, mul_a4, mul_b1, mul_b2, mul_b3, mul_b4;
  logic        mul_rst, mul_done;
  logic [15:0] mul_r1, mul_r2, mul_r3, mul_r4, out_data;
  logic        out_valid, out_ready = 0, busy, err_timeout;
  bit          never_done = 0;
  logic        prev_rst = 1;
  int          n_vec = 0, n_err = 0, n_arm = 0;
  logic [7:0]  ops [8];

  always #5 clk = ~clk;

  matmul_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mul_a1(mul_a1), .mul_a2(mul_a2), .mul_a3(mul_a3), .mul_a4(mul_a4),
    .mul_b1(mul_b1), .mul_b2(mul_b2), .mul_b3(mul_b3), .mul_b4(mul_b4),
    .mul_rst(mul_rst), .mul_r1(mul_r1), .mul_r2(mul_r2), .mul_r3(mul_r3), .mul_r4(mul_r4),
    .mul_done(mul_done), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  function automatic logic [15:0] mac(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
    return 16'(a) * 16'(b) + 16'(c) * 16'(d);
  endfunction

  // stub multiplier: one cycle out of reset it presents results and done
  always @(posedge clk) begin
    if (mul_rst) begin
      mul_done <= 1'b0;
      {mul_r1, mul_r2, mul_r3, mul_r4} <= '0;
    end else if (!never_done) begin
      mul_r1   <= mac(mul_a1, mul_b1, mul_a2, mul_b3);
      mul_r2   <= mac(mul_a1, mul_b2, mul_a2, mul_b4);
      mul_r3   <= mac(mul_a3, mul_b1, mul_a4, mul_b3);
      mul_r4   <= mac(mul_a3, mul_b2, mul_a4, mul_b4);
      mul_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (prev_rst && !mul_rst) n_arm++;
    prev_rst = mul_rst;
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // C = A*B with A=[a1 a2;a3 a4], B=[b1 b2;b3 b4], words in row-major order
  function automatic logic [15:0] ref_word(int w);
    int i = w / 2, j = w % 2, s = 0;
    for (int k = 0; k < 2; k++) s += int'(ops[i*2+k]) * int'(ops[4+k*2+j]);
    return 16'(s);
  endfunction

  task automatic rand_ops();
    for (int k = 0; k < 8; k++) ops[k] = 8'($urandom);
  endtask

  task automatic send(input bit toggle);
    int i = 0, cyc = 0;
    bit fire;
    while (i < 8 && cyc < 200) begin
      @(negedge clk);
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = ops[i];
      fire     = in_valid && in_ready;
      cyc++;
      @(posedge clk);
      if (fire) i++;
    end
    if (i < 8) chk("send_bytes", 64'(i), 64'd8);
  endtask

  task automatic recv(input int stall, input int nw, output int lat);
    logic [15:0] hold;
    lat = 0;
    for (int w = 0; w < nw; w++) begin
      int g = 0;
      do begin
        @(negedge clk);
        in_valid = 0;
        g++;
      end while (!out_valid && g < 100);
      if (w == 0) lat = g - 1;
      if (!out_valid) begin
        chk("out_valid_wait", 64'(out_valid), 64'd1);
        return;
      end
      hold = out_data;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("stall_hold", {out_valid, out_data}, {1'b1, hold});
      end
      chk($sformatf("r%0d", w + 1), 64'(out_data), 64'(ref_word(w)));
      out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
    end
  endtask

  task automatic run_job(input bit toggle, input int stall, input bit chk_lat);
    int lat;
    int arm0 = n_arm;
    send(toggle);
    recv(stall, 4, lat);
    if (chk_lat) chk("latency", 64'(lat), 64'd4);
    chk("operands", {mul_a1, mul_a2, mul_a3, mul_a4, mul_b1, mul_b2, mul_b3, mul_b4},
        {ops[0], ops[1], ops[2], ops[3], ops[4], ops[5], ops[6], ops[7]});
    @(negedge clk);
    chk("in_ready_next", 64'(in_ready), 64'd1);
    chk("arm_pulses", 64'(n_arm - arm0), 64'd1);
    chk("err_clear", 64'(err_timeout), 64'd0);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {in_ready, mul_rst, out_valid, busy, err_timeout}, 64'b11000);
    chk("rst_data", {out_data, mul_a1, mul_b4}, 64'd0);
    rst_n = 1;
    ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    run_job(0, 0, 1);
    ops = '{default: 8'hFF};
    run_job(0, 0, 1);
    ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    run_job(1, 3, 0);
    // multiplier that never finishes
    never_done = 1;
    rand_ops();
    send(0);
    repeat (16) begin
      @(negedge clk);
      in_valid = 0;
    end
    chk("to_before", {err_timeout, in_ready}, 64'b00);
    @(negedge clk);
    chk("to_after", {err_timeout, in_ready, mul_rst, busy}, 64'b1110);
    never_done = 0;
    rst_n = 0;
    #1 chk("to_rst_clear", 64'(err_timeout), 64'd0);
    @(negedge clk) rst_n = 1;
    // reset while unloading, after r2
    rand_ops();
    send(0);
    recv(0, 2, lat);
    @(negedge clk);
    chk("unload_live", 64'(out_valid), 64'd1);
    rst_n = 0;
    #1 chk("async_abort", {out_valid, mul_rst, in_ready, busy}, 64'b0110);
    @(negedge clk) rst_n = 1;
    rand_ops();
    run_job(0, 0, 1);
    rand_ops();
    run_job(0, 0, 1);
    for (int j = 0; j < 8; j++) begin
      rand_ops();
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
